// File: rtl/gpio_bitbang_pkg.sv
// Shared types and helpers for the GPIO bit-bang command receiver.
package gpio_bitbang_pkg;

  typedef enum logic [1:0] {
    DISABLED,
    IDLE,
    RECV
  } state_t;

  localparam int CNT_W = 8;

  // Timeout counter only needs to reach TIMEOUT_CYC-1.
  function automatic int tmo_w(input int timeout_cyc);
    return (timeout_cyc <= 2) ? 1 : $clog2(timeout_cyc);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/gpio_bitbang_rx_sync2.sv
// Two-flop synchroniser for an asynchronous GPIO pin, synchronous reset to 0.
module gpio_sync2 (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/gpio_bitbang_rx.sv
// Receives MSB-first even-parity frames bit-banged over a data/strobe GPIO pair.
//   state    | meaning
//   DISABLED | MSS not ready, edges ignored, frame state cleared
//   IDLE     | waiting for the first strobe edge of a frame
//   RECV     | frame partially received, timeout armed
module gpio_bitbang_rx
  import gpio_bitbang_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              CLK_BASE,
  input  logic              RESET_N,
  input  logic              MSS_READY,
  input  logic              GPIO_DATA,
  input  logic              GPIO_STROBE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              PARITY_ERR,
  output logic              TIMEOUT_ERR,
  output logic              BUSY,
  output logic [CNT_W-1:0]  FRAME_CNT,
  output logic [CNT_W-1:0]  ERR_CNT
);

  localparam int TMO_W = tmo_w(TIMEOUT_CYC);
  localparam int BIT_W = $clog2(DATA_W + 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [BIT_W-1:0] PAR_IDX  = BIT_W'(DATA_W);

  state_t            state;
  logic              data_s;
  logic              strb_s;
  logic              strb_d;
  logic              strb_rise;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W:0]   sh_ext;
  logic              par_acc;
  logic [BIT_W-1:0]  bit_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  gpio_sync2 u_sync_data (
    .clk_sys (CLK_BASE),
    .rst_b   (RESET_N),
    .d       (GPIO_DATA),
    .q       (data_s)
  );

  gpio_sync2 u_sync_strb (
    .clk_sys (CLK_BASE),
    .rst_b   (RESET_N),
    .d       (GPIO_STROBE),
    .q       (strb_s)
  );

  assign strb_rise = strb_s & ~strb_d;
  // Widened concat keeps the shift legal for DATA_W == 1.
  assign sh_ext    = {shreg, data_s};
  assign BUSY      = (state == RECV);

  always_ff @(posedge CLK_BASE) begin
    if (!RESET_N) begin
      state       <= DISABLED;
      strb_d      <= 1'b0;
      shreg       <= '0;
      par_acc     <= 1'b0;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      RX_DATA     <= '0;
      RX_VALID    <= 1'b0;
      PARITY_ERR  <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      FRAME_CNT   <= '0;
      ERR_CNT     <= '0;
    end else begin
      strb_d      <= strb_s;
      RX_VALID    <= 1'b0;
      PARITY_ERR  <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      if (!MSS_READY) begin
        state   <= DISABLED;
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else begin
        case (state)
          DISABLED: begin
            state   <= IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
          end
          IDLE: begin
            tmo_cnt <= '0;
            if (strb_rise) begin
              shreg   <= sh_ext[DATA_W-1:0];
              par_acc <= data_s;
              bit_cnt <= BIT_W'(1);
              state   <= RECV;
            end else begin
              bit_cnt <= '0;
            end
          end
          RECV: begin
            // An edge on the terminal-count cycle takes priority over the abort.
            if (strb_rise) begin
              tmo_cnt <= '0;
              if (bit_cnt == PAR_IDX) begin
                bit_cnt <= '0;
                state   <= IDLE;
                if (par_acc ^ data_s) begin
                  PARITY_ERR <= 1'b1;
                  ERR_CNT    <= sat_inc(ERR_CNT);
                end else begin
                  RX_DATA   <= shreg;
                  RX_VALID  <= 1'b1;
                  FRAME_CNT <= FRAME_CNT + CNT_W'(1);
                end
              end else begin
                shreg   <= sh_ext[DATA_W-1:0];
                par_acc <= par_acc ^ data_s;
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end else if (tmo_cnt == TMO_LAST) begin
              TIMEOUT_ERR <= 1'b1;
              ERR_CNT     <= sat_inc(ERR_CNT);
              bit_cnt     <= '0;
              tmo_cnt     <= '0;
              state       <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          default: state <= DISABLED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_bitbang_rx.sv
// Self-checking bench for gpio_bitbang_rx: vector table plus scoreboard of output pulses.
module tb_gpio_bitbang_rx;

  localparam int DATA_W = 8;
  localparam int TO_CYC = 16;

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_PERR  = 3'b010;
  localparam logic [2:0] K_TERR  = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    logic [7:0] fcnt;
    logic [7:0] ecnt;
  } ev_t;

  typedef struct {
    logic [7:0] payload;
    logic       flip;
  } vec_t;

  logic clk = 1'b0;
  logic RESET_N, MSS_READY, GPIO_DATA, GPIO_STROBE;
  logic [DATA_W-1:0] RX_DATA;
  logic RX_VALID, PARITY_ERR, TIMEOUT_ERR, BUSY;
  logic [7:0] FRAME_CNT, ERR_CNT;

  int n_cmp = 0;
  int n_err = 0;
  ev_t sb_q[$];
  ev_t mon_e;
  vec_t tbl[6];

  logic [7:0] exp_rx, exp_fcnt, exp_ecnt;

  gpio_bitbang_rx #(.DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .CLK_BASE    (clk),
    .RESET_N     (RESET_N),
    .MSS_READY   (MSS_READY),
    .GPIO_DATA   (GPIO_DATA),
    .GPIO_STROBE (GPIO_STROBE),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .PARITY_ERR  (PARITY_ERR),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .BUSY        (BUSY),
    .FRAME_CNT   (FRAME_CNT),
    .ERR_CNT     (ERR_CNT)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    GPIO_DATA = b;
    tick(1);
    GPIO_STROBE = 1'b1;
    tick(2);
    GPIO_STROBE = 1'b0;
    tick(1);
  endtask

  task automatic push_frame(input logic [7:0] p, input logic flip);
    ev_t e;
    if (flip) begin
      exp_ecnt = (exp_ecnt == 8'hFF) ? exp_ecnt : exp_ecnt + 8'd1;
      e.kind = K_PERR;
    end else begin
      exp_rx   = p;
      exp_fcnt = exp_fcnt + 8'd1;
      e.kind   = K_VALID;
    end
    e.data = exp_rx;
    e.fcnt = exp_fcnt;
    e.ecnt = exp_ecnt;
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] p, input logic flip);
    push_frame(p, flip);
    for (int i = 7; i >= 0; i--) send_bit(p[i]);
    send_bit((^p) ^ flip);
    tick(4);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"}, 32'(RX_DATA), 32'h0);
    check({tag, "_rx_valid"}, 32'(RX_VALID), 32'h0);
    check({tag, "_parity_err"}, 32'(PARITY_ERR), 32'h0);
    check({tag, "_timeout_err"}, 32'(TIMEOUT_ERR), 32'h0);
    check({tag, "_busy"}, 32'(BUSY), 32'h0);
    check({tag, "_frame_cnt"}, 32'(FRAME_CNT), 32'h0);
    check({tag, "_err_cnt"}, 32'(ERR_CNT), 32'h0);
  endtask

  always @(negedge clk) begin
    if (RESET_N === 1'b1 && (RX_VALID | PARITY_ERR | TIMEOUT_ERR)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got valid/perr/terr=%b expected no pulse at %0t",
                 {RX_VALID, PARITY_ERR, TIMEOUT_ERR}, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("evt_kind", 32'({RX_VALID, PARITY_ERR, TIMEOUT_ERR}), 32'(mon_e.kind));
        check("evt_rx_data", 32'(RX_DATA), 32'(mon_e.data));
        check("evt_frame_cnt", 32'(FRAME_CNT), 32'(mon_e.fcnt));
        check("evt_err_cnt", 32'(ERR_CNT), 32'(mon_e.ecnt));
      end
    end
  end

  initial begin
    ev_t e;
    RESET_N = 1'b0; MSS_READY = 1'b0; GPIO_DATA = 1'b0; GPIO_STROBE = 1'b0;
    exp_rx = '0; exp_fcnt = '0; exp_ecnt = '0;

    tbl[0] = '{payload: 8'h3C, flip: 1'b1};
    tbl[1] = '{payload: 8'h81, flip: 1'b0};
    tbl[2] = '{payload: 8'h00, flip: 1'b0};
    tbl[3] = '{payload: 8'hFF, flip: 1'b0};
    tbl[4] = '{payload: 8'h7E, flip: 1'b1};
    tbl[5] = '{payload: 8'h01, flip: 1'b0};

    tick(3);
    check_all_zero("reset");
    RESET_N = 1'b1;
    MSS_READY = 1'b1;
    tick(3);

    // 0xA5 with exact latency on the parity bit
    push_frame(8'hA5, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'hA5 >> i));
    check("busy_mid_frame", 32'(BUSY), 32'h1);
    GPIO_DATA = 1'b0;
    tick(1);
    GPIO_STROBE = 1'b1;
    tick(2);
    check("valid_not_early", 32'(RX_VALID), 32'h0);
    tick(1);
    check("valid_lat3", 32'(RX_VALID), 32'h1);
    check("rx_data_a5", 32'(RX_DATA), 32'hA5);
    check("frame_cnt_1", 32'(FRAME_CNT), 32'h1);
    GPIO_STROBE = 1'b0;
    tick(1);
    check("valid_one_cycle", 32'(RX_VALID), 32'h0);
    tick(3);
    check("busy_after_frame", 32'(BUSY), 32'h0);

    for (int v = 0; v < 6; v++) send_frame(tbl[v].payload, tbl[v].flip);
    check("tbl_frame_cnt", 32'(FRAME_CNT), 32'(exp_fcnt));
    check("tbl_err_cnt", 32'(ERR_CNT), 32'(exp_ecnt));
    check("tbl_rx_data", 32'(RX_DATA), 32'(exp_rx));

    // timeout after 4 bits, then a good frame
    for (int i = 0; i < 4; i++) send_bit(1'(i));
    check("busy_before_timeout", 32'(BUSY), 32'h1);
    exp_ecnt = exp_ecnt + 8'd1;
    e.kind = K_TERR; e.data = exp_rx; e.fcnt = exp_fcnt; e.ecnt = exp_ecnt;
    sb_q.push_back(e);
    tick(30);
    check("busy_after_timeout", 32'(BUSY), 32'h0);
    send_frame(8'h81, 1'b0);

    // MSS_READY drop mid-frame discards silently
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    MSS_READY = 1'b0;
    tick(4);
    MSS_READY = 1'b1;
    tick(2);
    check("ready_drop_busy", 32'(BUSY), 32'h0);
    check("ready_drop_fcnt", 32'(FRAME_CNT), 32'(exp_fcnt));
    check("ready_drop_ecnt", 32'(ERR_CNT), 32'(exp_ecnt));
    send_frame(8'h12, 1'b0);
    check("after_ready_rx", 32'(RX_DATA), 32'h12);

    for (int i = 0; i < 256; i++) send_frame(8'(i * 7 + 3), 1'b0);
    check("frame_cnt_wrap", 32'(FRAME_CNT), 32'(exp_fcnt));

    for (int i = 0; i < 300; i++) send_frame(8'(i), 1'b1);
    check("err_cnt_sat", 32'(ERR_CNT), 32'hFF);

    // reset pulse mid-frame
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    RESET_N = 1'b0;
    tick(1);
    check_all_zero("midreset");
    RESET_N = 1'b1;
    exp_rx = '0; exp_fcnt = '0; exp_ecnt = '0;
    tick(2);
    send_frame(8'hC3, 1'b0);
    check("post_reset_fcnt", 32'(FRAME_CNT), 32'h1);

    tick(5);
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
